// File: rtl/lock_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lock_req_arbiter_pkg
//   Shared definitions for the lock/unlock command arbiter and its
//   round-robin selector. Command payloads pass through untouched, so the
//   only shared items are the beat width and a modulo helper.
// ---------------------------------------------------------------------------
package lock_req_arbiter_pkg;

    // Width of one lock/unlock command beat.
    localparam int DATA_BITS = 64;

    // Wrap an index that may exceed n-1 by at most n back into [0, n-1].
    // Cheaper than a general modulo because a single subtraction is enough.
    function automatic int rrWrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/lock_req_arbiter_sel.sv
// ---------------------------------------------------------------------------
// rr_priority_select
//   Combinational round-robin pick: returns the first asserted request
//   found when scanning last+1, last+2, ... modulo NUM_ACCS. Kept generic so
//   the other manager arbiters can reuse it.
//
//   req   in   NUM_ACCS   request vector
//   last  in   ACC_BITS   index granted most recently (lowest priority now)
//   any   out  1          at least one request present
//   idx   out  ACC_BITS   selected index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_priority_select
    import lock_req_arbiter_pkg::*;
#(
    parameter int NUM_ACCS = 16,
    parameter int ACC_BITS = 4
) (
    input  logic [NUM_ACCS-1:0] req,
    input  logic [ACC_BITS-1:0] last,
    output logic                any,
    output logic [ACC_BITS-1:0] idx
);

    always_comb begin
        int cand;
        // NOTE: every output of a combinational block is given a default
        // before any conditional assignment, so no path leaves it unassigned
        // and no latch is inferred.
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        // Offset NUM_ACCS lands back on 'last' itself, so a lone requester
        // that was served previously is still found.
        for (int off = 1; off <= NUM_ACCS; off++) begin
            cand = rrWrap(int'(last) + off, NUM_ACCS);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = ACC_BITS'(cand);
            end
        end
    end

endmodule

// File: rtl/lock_req_arbiter.sv
// ---------------------------------------------------------------------------
// lock_req_arbiter
//   Merges the lock/unlock command streams of NUM_ACCS accelerators into the
//   single stream feeding the lock manager. A grant is held until the TLAST
//   beat, so packets never interleave; each forwarded beat carries its source
//   index on out_TID, which the lock manager uses as the ack TDEST.
//
//   clk         in   1                  clock
//   rstn        in   1                  synchronous active-low reset
//   in_TDATA    in   NUM_ACCS*64        command words, stream i at [64*i+:64]
//   in_TVALID   in   NUM_ACCS           per-stream valid
//   in_TLAST    in   NUM_ACCS           per-stream end of packet
//   in_TREADY   out  NUM_ACCS           per-stream ready (only the grant)
//   out_TDATA   out  64                 forwarded word (registered)
//   out_TVALID  out  1                  output valid (registered)
//   out_TID     out  ACC_BITS           source index (registered)
//   out_TLAST   out  1                  forwarded TLAST (registered)
//   out_TREADY  in   1                  downstream ready
// ---------------------------------------------------------------------------
module lock_req_arbiter
    import lock_req_arbiter_pkg::*;
#(
    parameter int ACC_BITS = 4,
    parameter int NUM_ACCS = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_ACCS*DATA_BITS-1:0] in_TDATA,
    input  logic [NUM_ACCS-1:0]           in_TVALID,
    input  logic [NUM_ACCS-1:0]           in_TLAST,
    output logic [NUM_ACCS-1:0]           in_TREADY,
    output logic [DATA_BITS-1:0]          out_TDATA,
    output logic                          out_TVALID,
    output logic [ACC_BITS-1:0]           out_TID,
    output logic                          out_TLAST,
    input  logic                          out_TREADY
);

    typedef enum logic {ARB, FWD} state_t;

    // Starting from NUM_ACCS-1 makes index 0 the first priority after reset.
    localparam logic [ACC_BITS-1:0] LAST_INIT = ACC_BITS'(NUM_ACCS - 1);

    state_t              state, stateNext;
    logic [ACC_BITS-1:0] grant, grantNext;
    logic [ACC_BITS-1:0] lastGrant, lastGrantNext;
    logic                reqAny;
    logic [ACC_BITS-1:0] reqIdx;
    logic                slotFree;
    logic                beatTaken;

    rr_priority_select #(
        .NUM_ACCS (NUM_ACCS),
        .ACC_BITS (ACC_BITS)
    ) uSel (
        .req  (in_TVALID),
        .last (lastGrant),
        .any  (reqAny),
        .idx  (reqIdx)
    );

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ARB;
            grant     <= '0;
            lastGrant <= LAST_INIT;
        end else begin
            state     <= stateNext;
            grant     <= grantNext;
            lastGrant <= lastGrantNext;
        end
    end

    always_comb begin
        stateNext     = state;
        grantNext     = grant;
        lastGrantNext = lastGrant;
        in_TREADY     = '0;
        beatTaken     = 1'b0;
        // The output slot can take a beat if empty or draining this cycle.
        slotFree      = !out_TVALID || out_TREADY;

        case (state)
            ARB: begin
                if (reqAny) begin
                    grantNext = reqIdx;
                    stateNext = FWD;
                end
            end
            FWD: begin
                // Only the granted stream sees ready; a stalled grant simply
                // waits here, nobody else is considered until its TLAST.
                in_TREADY[grant] = slotFree;
                beatTaken        = in_TVALID[grant] && slotFree;
                if (beatTaken && in_TLAST[grant]) begin
                    lastGrantNext = grant;
                    stateNext     = ARB;
                end
            end
        endcase
    end

    // Single registered output slice. A load in the same cycle as a drain
    // replaces the old beat, which keeps one beat per cycle within a packet.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_TVALID <= 1'b0;
            out_TDATA  <= '0;
            out_TID    <= '0;
            out_TLAST  <= 1'b0;
        end else if (beatTaken) begin
            out_TVALID <= 1'b1;
            out_TDATA  <= in_TDATA[DATA_BITS*int'(grant) +: DATA_BITS];
            out_TID    <= grant;
            out_TLAST  <= in_TLAST[grant];
        end else if (out_TREADY) begin
            out_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lock_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lock_req_arbiter
//   Scoreboard bench: each test queues source beats and, at the same time,
//   the output beats it expects in the order round-robin must produce them.
//   Output handshakes pop and compare. Inputs change just after the rising
//   edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lock_req_arbiter;

    localparam int ACC_BITS = 4;
    localparam int NUM_ACCS = 16;
    localparam int W        = 64;
    localparam int DEPTH    = 16;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NUM_ACCS*W-1:0] in_TDATA;
    logic [NUM_ACCS-1:0]   in_TVALID;
    logic [NUM_ACCS-1:0]   in_TLAST;
    logic [NUM_ACCS-1:0]   in_TREADY;
    logic [W-1:0]          out_TDATA;
    logic                  out_TVALID;
    logic [ACC_BITS-1:0]   out_TID;
    logic                  out_TLAST;
    logic                  out_TREADY;

    always #5 clk = ~clk;

    lock_req_arbiter #(
        .ACC_BITS (ACC_BITS),
        .NUM_ACCS (NUM_ACCS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TLAST   (in_TLAST),
        .in_TREADY  (in_TREADY),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TID    (out_TID),
        .out_TLAST  (out_TLAST),
        .out_TREADY (out_TREADY)
    );

    typedef struct packed {
        logic [ACC_BITS-1:0] tid;
        logic [W-1:0]        data;
        logic                last;
    } beat_t;

    beat_t               expQ[$];
    logic [W-1:0]        srcData [NUM_ACCS][DEPTH];
    logic                srcLast [NUM_ACCS][DEPTH];
    int                  srcHead [NUM_ACCS];
    int                  srcTail [NUM_ACCS];
    logic [NUM_ACCS-1:0] accepted;

    int    total = 0;
    int    bad   = 0;
    int    cyc;
    int    firstOut;
    int    rdyCnt [NUM_ACCS];
    int    outCyc[$];
    logic  prevHold;
    beat_t prevOut;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pushBeat(input int src, input logic [W-1:0] d, input logic l);
        srcData[src][srcTail[src]] = d;
        srcLast[src][srcTail[src]] = l;
        srcTail[src]++;
    endtask

    task automatic expBeat(input int src, input logic [W-1:0] d, input logic l);
        beat_t e;
        e.tid  = ACC_BITS'(src);
        e.data = d;
        e.last = l;
        expQ.push_back(e);
    endtask

    function automatic logic srcBusy();
        logic busy = 1'b0;
        for (int i = 0; i < NUM_ACCS; i++)
            if (srcHead[i] < srcTail[i]) busy = 1'b1;
        return busy;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_ACCS; i++) begin
            if (srcHead[i] < srcTail[i]) begin
                in_TVALID[i]       = 1'b1;
                in_TDATA[i*W +: W] = srcData[i][srcHead[i]];
                in_TLAST[i]        = srcLast[i][srcHead[i]];
            end else begin
                in_TVALID[i]       = 1'b0;
                in_TDATA[i*W +: W] = '0;
                in_TLAST[i]        = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        beat_t e;
        if (out_TVALID && out_TREADY) begin
            outCyc.push_back(cyc);
            if (expQ.size() == 0) begin
                check("unexpected_out", 1'b1, 1'b0);
            end else begin
                e = expQ.pop_front();
                check("out_tid", out_TID, e.tid);
                check("out_data", out_TDATA, e.data);
                check("out_last", out_TLAST, e.last);
            end
        end
        if (out_TVALID && firstOut < 0) firstOut = cyc;
        if (prevHold) begin
            check("hold_valid", out_TVALID, 1'b1);
            check("hold_data", out_TDATA, prevOut.data);
            check("hold_tid", out_TID, prevOut.tid);
            check("hold_last", out_TLAST, prevOut.last);
        end
        prevHold     = out_TVALID && !out_TREADY;
        prevOut.tid  = out_TID;
        prevOut.data = out_TDATA;
        prevOut.last = out_TLAST;
        check("ready_onehot", $countones(in_TREADY) <= 1, 1'b1);
        for (int i = 0; i < NUM_ACCS; i++) begin
            accepted[i] = in_TVALID[i] && in_TREADY[i];
            if (in_TREADY[i]) rdyCnt[i]++;
        end
        cyc++;
    endtask

    task automatic retire();
        for (int i = 0; i < NUM_ACCS; i++)
            if (accepted[i]) srcHead[i]++;
        accepted = '0;
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        retire();
    endtask

    task automatic startTest();
        cyc      = 0;
        firstOut = -1;
        outCyc.delete();
        for (int i = 0; i < NUM_ACCS; i++) rdyCnt[i] = 0;
    endtask

    task automatic clearStim();
        for (int i = 0; i < NUM_ACCS; i++) begin
            srcHead[i] = 0;
            srcTail[i] = 0;
        end
        expQ.delete();
        accepted = '0;
        prevHold = 1'b0;
        drive();
    endtask

    task automatic doReset();
        rstn = 1'b0;
        clearStim();
        out_TREADY = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic runUntilEmpty(input int maxCycles);
        int n = 0;
        while ((expQ.size() != 0 || srcBusy()) && n < maxCycles) begin
            tick();
            n++;
        end
        check("drain_in_time", n < maxCycles, 1'b1);
        check("exp_empty", expQ.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;

        in_TDATA   = '0;
        in_TVALID  = '0;
        in_TLAST   = '0;
        out_TREADY = 1'b1;
        rstn       = 1'b0;
        clearStim();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", out_TVALID, 1'b0);
        check("rst_out_data", out_TDATA, 64'h0);
        check("rst_out_tid", out_TID, 0);
        check("rst_out_last", out_TLAST, 1'b0);
        check("rst_in_ready", in_TREADY, 0);
        rstn = 1'b1;

        // Single requester 5, one-beat lock command.
        startTest();
        pushBeat(5, 64'h1234_5678_9ABC_DE01, 1'b1);
        expBeat(5, 64'h1234_5678_9ABC_DE01, 1'b1);
        runUntilEmpty(20);
        repeat (3) tick();
        check("t1_latency", firstOut, 2);
        check("t1_ready5_cycles", rdyCnt[5], 1);

        // Sources 0 and 3 together: strict alternation.
        doReset();
        startTest();
        for (int k = 0; k < 3; k++) begin
            d = 64'hA000_0000_0000_0000 | 64'(k);
            pushBeat(0, d, 1'b1);
            expBeat(0, d, 1'b1);
            d = 64'hB300_0000_0000_0000 | 64'(k);
            pushBeat(3, d, 1'b1);
            expBeat(3, d, 1'b1);
        end
        runUntilEmpty(60);

        // Source 2 three-beat packet holds the grant over requester 1.
        doReset();
        startTest();
        for (int k = 0; k < 3; k++) begin
            d = 64'hC200_0000_0000_0010 + 64'(k);
            pushBeat(2, d, k == 2);
            expBeat(2, d, k == 2);
        end
        tick();
        pushBeat(1, 64'hD100_0000_0000_0001, 1'b1);
        expBeat(1, 64'hD100_0000_0000_0001, 1'b1);
        runUntilEmpty(40);
        check("t3_ready1_cycles", rdyCnt[1], 1);
        check("t3_out_count", outCyc.size(), 4);
        if (outCyc.size() == 4) begin
            check("t3_gap01", outCyc[1] - outCyc[0], 1);
            check("t3_gap12", outCyc[2] - outCyc[1], 1);
            check("t3_bubble", outCyc[3] - outCyc[2], 2);
        end

        // Downstream stall for four cycles with a beat held.
        doReset();
        startTest();
        out_TREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = 64'hE400_0000_0000_0100 + 64'(k);
            pushBeat(4, d, k == 2);
            expBeat(4, d, k == 2);
        end
        repeat (6) tick();
        check("t4_stall_valid", out_TVALID, 1'b1);
        check("t4_stall_ready4", rdyCnt[4], 1);
        check("t4_stall_no_out", outCyc.size(), 0);
        out_TREADY = 1'b1;
        runUntilEmpty(30);
        check("t4_out_count", outCyc.size(), 3);
        if (outCyc.size() == 3) begin
            check("t4_release_cycle", outCyc[0], 6);
            check("t4_drain_and_load", outCyc[1] - outCyc[0], 1);
        end

        // Reset mid-packet from source 7, after 7 has been served once.
        doReset();
        startTest();
        pushBeat(7, 64'hF700_0000_0000_0001, 1'b1);
        expBeat(7, 64'hF700_0000_0000_0001, 1'b1);
        runUntilEmpty(20);
        out_TREADY = 1'b0;
        for (int k = 0; k < 4; k++)
            pushBeat(7, 64'hF700_0000_0000_0A00 + 64'(k), k == 3);
        repeat (3) tick();
        check("t5_pre_rst_valid", out_TVALID, 1'b1);
        rstn = 1'b0;
        clearStim();
        out_TREADY = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_valid", out_TVALID, 1'b0);
        check("t5_rst_ready", in_TREADY, 0);
        rstn = 1'b1;
        startTest();
        pushBeat(9, 64'h0900_0000_0000_0009, 1'b1);
        pushBeat(6, 64'h0600_0000_0000_0006, 1'b1);
        expBeat(6, 64'h0600_0000_0000_0006, 1'b1);
        expBeat(9, 64'h0900_0000_0000_0009, 1'b1);
        runUntilEmpty(30);

        // Sustained eight-beat packet at full rate.
        doReset();
        startTest();
        for (int k = 0; k < 8; k++) begin
            d = 64'h1B00_0000_0000_0000 + 64'(k * 3);
            pushBeat(11, d, k == 7);
            expBeat(11, d, k == 7);
        end
        runUntilEmpty(40);
        check("t6_out_count", outCyc.size(), 8);
        if (outCyc.size() == 8)
            check("t6_no_bubbles", outCyc[7] - outCyc[0], 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
